// File: rtl/led_zone_shifter.sv
// led_zone_shifter
//
// Captures per-zone backlight values into a double-buffered zone memory and,
// on each frame refresh, swaps banks and shifts the completed frame out to a
// daisy chain of MiniLED driver ICs over a clock/data/latch serial link.
//
// Ports
//   sys_clk        pixel clock, the only clock
//   sys_rst        asynchronous, active-low reset
//   light          zone brightness value
//   light_index    zone index for light
//   light_vld      write strobe for light/light_index
//   light_refresh  one-cycle pulse: current frame's writes are complete
//   led_sclk       driver shift clock
//   led_sdo        driver serial data, MSB first, zone ZONES-1 first
//   led_lat        driver latch pulse
//   busy           high from bank swap through the DONE cycle
//   frame_done     one-cycle pulse after the latch completes
//   overrun        sticky: refresh arrived while one was already pending
//
// Handshake: light_vld and light_refresh are plain strobes with no ready
// signal; the block accepts a write or a refresh on every cycle they are high,
// in any state. Refreshes arriving while busy are queued (depth one) and
// further ones are flagged on overrun.

module led_zone_shifter #(
    parameter int ZONES   = 288,
    parameter int CLK_DIV = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [15:0] light,
    input  logic [8:0]  light_index,
    input  logic        light_vld,
    input  logic        light_refresh,
    output logic        led_sclk,
    output logic        led_sdo,
    output logic        led_lat,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam int              AW        = $clog2(2 * ZONES);
    localparam int              DIV_W     = $clog2(2 * CLK_DIV) > 0 ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [9:0]      ZONES_L   = 10'(ZONES);
    localparam logic [8:0]      WORD_LAST = 9'(ZONES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] LAT_LAST = DIV_W'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             bank_q, bank_d;        // write bank; read bank is ~bank_q
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic [8:0]       word_q, word_d;
    logic [3:0]       bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      shreg_q;
    logic             shift_load, shift_step, shift_clr;

    logic [15:0]      mem_q [0:2*ZONES-1];
    logic [AW-1:0]    wr_addr, rd_addr;
    logic             wr_en;

    // Bank 0 occupies addresses 0..ZONES-1, bank 1 ZONES..2*ZONES-1.
    assign wr_en   = light_vld && ({1'b0, light_index} < ZONES_L);
    assign wr_addr = bank_q ? AW'(ZONES_L + {1'b0, light_index}) : AW'(light_index);
    assign rd_addr = bank_q ? AW'(word_q) : AW'(ZONES_L + {1'b0, word_q});

    // Writes use the write bank as it stands this cycle, so a write coinciding
    // with a swap lands in the bank being handed to the shifter.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= light;
        end
    end

    // The shift register doubles as the memory's registered read port.
    // It is cleared entering LATCH so the next frame's LOAD cycle drives 0.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            shreg_q <= '0;
        end else if (shift_load) begin
            shreg_q <= mem_q[rd_addr];
        end else if (shift_step) begin
            shreg_q <= {shreg_q[14:0], 1'b0};
        end else if (shift_clr) begin
            shreg_q <= '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q   <= S_IDLE;
            bank_q    <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            word_q    <= '0;
            bit_q     <= '0;
            div_q     <= '0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            word_q    <= word_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        word_d     = word_q;
        bit_d      = bit_q;
        div_d      = div_q;
        shift_load = 1'b0;
        shift_step = 1'b0;
        shift_clr  = 1'b0;

        if (light_refresh && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
            if (pending_q) begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (light_refresh || pending_q) begin
                    bank_d    = ~bank_q;
                    pending_d = 1'b0;
                    word_d    = WORD_LAST;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_load = 1'b1;
                bit_d      = 4'd15;
                div_d      = '0;
                state_d    = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_SHIFT_HI;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == 4'd0) begin
                        if (word_q == 9'd0) begin
                            shift_clr = 1'b1;
                            state_d   = S_LATCH;
                        end else begin
                            word_d  = word_q - 9'd1;
                            state_d = S_LOAD;
                        end
                    end else begin
                        bit_d      = bit_q - 4'd1;
                        shift_step = 1'b1;
                        state_d    = S_SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (div_q == LAT_LAST) begin
                    div_d   = '0;
                    state_d = S_DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state, so reset forces them low
    // asynchronously. In LOAD, sdo keeps the previous word's last bit.
    assign led_sclk   = (state_q == S_SHIFT_HI);
    assign led_lat    = (state_q == S_LATCH);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign overrun    = overrun_q;
    assign led_sdo    = ((state_q == S_LOAD) || (state_q == S_SHIFT_LO) ||
                         (state_q == S_SHIFT_HI)) ? shreg_q[15] : 1'b0;

endmodule

// File: tb/tb_led_zone_shifter.sv
module tb_led_zone_shifter;

    localparam int ZONES      = 4;
    localparam int CLK_DIV    = 1;
    localparam int FRAME_BUSY = ZONES * (1 + 32 * CLK_DIV) + 2 * CLK_DIV + 1;

    // ---------------- clock / reset ----------------
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [15:0] light = '0;
    logic [8:0]  light_index = '0;
    logic        light_vld = 1'b0;
    logic        light_refresh = 1'b0;
    logic        led_sclk, led_sdo, led_lat, busy, frame_done, overrun;

    always #5 sys_clk = ~sys_clk;

    led_zone_shifter #(.ZONES(ZONES), .CLK_DIV(CLK_DIV)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .light         (light),
        .light_index   (light_index),
        .light_vld     (light_vld),
        .light_refresh (light_refresh),
        .led_sclk      (led_sclk),
        .led_sdo       (led_sdo),
        .led_lat       (led_lat),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun)
    );

    // ---------------- scoreboard / model ----------------
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_mem [0:1][0:ZONES-1];
    logic        model_wb = 1'b0;
    logic        model_pend = 1'b0;
    logic        model_ovr = 1'b0;

    int          busy_run = 0, last_busy_len = 0, idle_run = 0, last_gap = 0;
    int          lat_run = 0, lat_before_done = 0, lat_total = 0;
    int          done_cnt = 0, glitch_cnt = 0, busy_total = 0, bit_n = 0;
    logic [15:0] shift_w = '0;
    logic [15:0] exp_w;
    logic        prev_busy = 1'b0, prev_sclk = 1'b0, prev_sdo = 1'b0, prev_lat = 1'b0;

    task automatic push_frame();
        for (int z = ZONES - 1; z >= 0; z--) begin
            exp_q.push_back(model_mem[model_wb][z]);
        end
        model_wb = ~model_wb;
    endtask

    // Monitor: samples on the falling edge, assembles words on sclk rises.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!sys_rst) begin
                prev_busy = 1'b0; prev_sclk = 1'b0; prev_sdo = 1'b0; prev_lat = 1'b0;
                bit_n = 0; busy_run = 0; idle_run = 0; lat_run = 0;
            end else begin
                if (!busy && model_pend) begin
                    push_frame();
                    model_pend = 1'b0;
                end
                if (busy) begin
                    if (!prev_busy) last_gap = idle_run;
                    busy_run++;
                    busy_total++;
                    idle_run = 0;
                end else begin
                    if (prev_busy) begin
                        last_busy_len = busy_run;
                        busy_run = 0;
                    end
                    idle_run++;
                end
                if (led_lat) begin
                    lat_run++;
                    lat_total++;
                end
                if (frame_done) begin
                    done_cnt++;
                    lat_before_done = prev_lat ? lat_run : 0;
                    lat_run = 0;
                end
                if (prev_sclk && led_sclk && (led_sdo !== prev_sdo)) glitch_cnt++;
                if (!prev_sclk && led_sclk) begin
                    shift_w = {shift_w[14:0], led_sdo};
                    bit_n++;
                    if (bit_n == 16) begin
                        bit_n = 0;
                        total_cnt++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL word_unexpected: got %h, none expected", shift_w);
                        end else begin
                            exp_w = exp_q.pop_front();
                            if (shift_w !== exp_w)
                                $display("FAIL shifted_word: got %h expected %h", shift_w, exp_w);
                            else
                                pass_cnt++;
                        end
                    end
                end
                prev_busy = busy; prev_sclk = led_sclk; prev_sdo = led_sdo; prev_lat = led_lat;
            end
        end
    end

    // ---------------- driver tasks (called just after a falling edge) ----------------
    task automatic write_word(input logic [8:0] idx, input logic [15:0] val);
        light = val; light_index = idx; light_vld = 1'b1;
        if (int'(idx) < ZONES) model_mem[model_wb][int'(idx)] = val;
        @(negedge sys_clk);
        light_vld = 1'b0;
    endtask

    task automatic refresh_model();
        if (!busy) begin
            push_frame();
        end else begin
            if (model_pend) model_ovr = 1'b1;
            model_pend = 1'b1;
        end
    endtask

    task automatic pulse_refresh();
        light_refresh = 1'b1;
        refresh_model();
        @(negedge sys_clk);
        light_refresh = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        total_cnt++;
        if (done_cnt == start) $display("FAIL %s_timeout: got no frame_done in %0d cycles, expected one", name, n);
        else pass_cnt++;
        @(negedge sys_clk);
    endtask

    task automatic check_frame_end(input string name);
        total_cnt++;
        if (last_busy_len !== FRAME_BUSY) $display("FAIL %s_busy_len: got %0d expected %0d", name, last_busy_len, FRAME_BUSY);
        else pass_cnt++;
        total_cnt++;
        if (lat_before_done !== 2 * CLK_DIV) $display("FAIL %s_latch_len: got %0d expected %0d", name, lat_before_done, 2 * CLK_DIV);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL %s_words_left: got %0d expected 0", name, exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (glitch_cnt !== 0) $display("FAIL %s_sdo_while_sclk_high: got %0d changes expected 0", name, glitch_cnt);
        else pass_cnt++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        total_cnt++;
        if ({led_sclk, led_sdo, led_lat, busy, frame_done, overrun} !== 6'b0)
            $display("FAIL reset_outputs: got %b expected 000000", {led_sclk, led_sdo, led_lat, busy, frame_done, overrun});
        else pass_cnt++;
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        total_cnt++;
        if ({led_sclk, led_sdo, led_lat, busy, frame_done, overrun} !== 6'b0)
            $display("FAIL idle_after_reset: got %b expected 000000", {led_sclk, led_sdo, led_lat, busy, frame_done, overrun});
        else pass_cnt++;
    endtask

    task automatic test_basic_frame();
        write_word(9'd0, 16'h0001);
        write_word(9'd1, 16'h8000);
        write_word(9'd2, 16'hA5A5);
        write_word(9'd3, 16'hFFFF);
        pulse_refresh();
        total_cnt++;
        if ({busy, led_sclk} !== 2'b10) $display("FAIL load_cycle: got busy,sclk=%b expected 10", {busy, led_sclk});
        else pass_cnt++;
        @(negedge sys_clk);
        total_cnt++;
        if ({led_sdo, led_sclk} !== 2'b10) $display("FAIL first_bit: got sdo,sclk=%b expected 10", {led_sdo, led_sclk});
        else pass_cnt++;
        @(negedge sys_clk);
        total_cnt++;
        if (led_sclk !== 1'b1) $display("FAIL first_rise: got %b expected 1", led_sclk);
        else pass_cnt++;
        for (int z = 0; z < ZONES; z++) write_word(9'(z), 16'h1234);
        wait_done("frame1");
        check_frame_end("frame1");
    endtask

    task automatic test_second_frame();
        pulse_refresh();
        wait_done("frame2");
        check_frame_end("frame2");
    endtask

    task automatic test_pending();
        int busy_snap;
        pulse_refresh();
        repeat (10) @(negedge sys_clk);
        pulse_refresh();
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL overrun_single_pending: got %b expected 0", overrun);
        else pass_cnt++;
        repeat (5) @(negedge sys_clk);
        pulse_refresh();
        total_cnt++;
        if (overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun);
        else pass_cnt++;
        wait_done("pend_first");
        wait_done("pend_restart");
        check_frame_end("pend_restart");
        total_cnt++;
        if (last_gap !== 1) $display("FAIL restart_gap: got %0d idle cycles expected 1", last_gap);
        else pass_cnt++;
        busy_snap = busy_total;
        repeat (20) @(negedge sys_clk);
        total_cnt++;
        if (busy_total !== busy_snap) $display("FAIL single_restart: got %0d extra busy cycles expected 0", busy_total - busy_snap);
        else pass_cnt++;
        total_cnt++;
        if (overrun !== model_ovr) $display("FAIL overrun_sticky: got %b expected %b", overrun, model_ovr);
        else pass_cnt++;
    endtask

    task automatic test_invalid_index();
        write_word(9'd4, 16'hDEAD);
        write_word(9'd511, 16'hC0DE);
        pulse_refresh();
        wait_done("inval_a");
        pulse_refresh();
        wait_done("inval_b");
        check_frame_end("inval_b");
    endtask

    task automatic test_simultaneous();
        light = 16'hBEEF; light_index = 9'd0; light_vld = 1'b1; light_refresh = 1'b1;
        model_mem[model_wb][0] = 16'hBEEF;
        refresh_model();
        @(negedge sys_clk);
        light_vld = 1'b0; light_refresh = 1'b0;
        wait_done("simul");
        check_frame_end("simul");
    endtask

    task automatic test_reset_mid_frame();
        int lat_snap, busy_snap;
        pulse_refresh();
        repeat (48) @(negedge sys_clk);
        lat_snap = lat_total;
        #2 sys_rst = 1'b0;
        #1;
        total_cnt++;
        if ({led_sclk, led_sdo, led_lat, busy, frame_done, overrun} !== 6'b0)
            $display("FAIL async_reset_outputs: got %b expected 000000", {led_sclk, led_sdo, led_lat, busy, frame_done, overrun});
        else pass_cnt++;
        model_wb = 1'b0; model_pend = 1'b0; model_ovr = 1'b0;
        exp_q.delete();
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        busy_snap = busy_total;
        repeat (100) @(negedge sys_clk);
        total_cnt++;
        if (busy_total !== busy_snap) $display("FAIL idle_after_abort: got %0d busy cycles expected 0", busy_total - busy_snap);
        else pass_cnt++;
        total_cnt++;
        if (lat_total !== lat_snap) $display("FAIL no_latch_on_abort: got %0d latch cycles expected 0", lat_total - lat_snap);
        else pass_cnt++;
        pulse_refresh();
        wait_done("post_reset");
        check_frame_end("post_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_second_frame();
        test_pending();
        test_invalid_index();
        test_simultaneous();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
